fcn_mac_sequencer: RTL

//  Drives one MAC accumulator through a fully-connected layer: reads activations and weights

---
 rtl/fcn_mac_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fcn_mac_sequencer.sv
// Fully-connected layer sequencer: walks activation/weight memories, feeds one MAC,
// and captures one signed accumulated sum per output neuron.
module fcn_mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int IN_LEN     = 784,
    parameter int OUT_LEN    = 10,
    parameter int AW_ACT     = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
    parameter int AW_W       = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
    parameter int AW_OUT     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  act_rd_en,
    output logic [AW_ACT-1:0]     act_addr,
    input  logic [DATA_WIDTH-1:0] act_data,
    output logic                  w_rd_en,
    output logic [AW_W-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  mac_input_valid,
    output logic                  mac_store,
    output logic [DATA_WIDTH-1:0] mac_input_data,
    output logic [DATA_WIDTH-1:0] mac_weight,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    input  logic                  mac_result_valid,
    output logic                  out_valid,
    output logic [AW_OUT-1:0]     out_idx,
    output logic [ACC_WIDTH-1:0]  out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_STORE,
        S_FINISH
    } state_t;

    localparam logic [AW_ACT-1:0] K_LAST = AW_ACT'(IN_LEN - 1);
    localparam logic [AW_OUT-1:0] N_LAST = AW_OUT'(OUT_LEN - 1);
    localparam logic [AW_W-1:0]   W_STEP = AW_W'(IN_LEN);

    state_t            state;
    logic [AW_OUT-1:0] n_idx;
    logic [AW_W-1:0]   w_base;

    // Memory read data lands one cycle after the address, so the MAC sees it directly.
    assign mac_input_data = act_data;
    assign mac_weight     = w_data;
    assign w_rd_en        = act_rd_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            act_rd_en       <= 1'b0;
            act_addr        <= '0;
            w_addr          <= '0;
            mac_input_valid <= 1'b0;
            mac_store       <= 1'b0;
            out_valid       <= 1'b0;
            out_idx         <= '0;
            out_data        <= '0;
            n_idx           <= '0;
            w_base          <= '0;
        end else begin
            mac_input_valid <= act_rd_en;
            out_valid       <= 1'b0;
            done            <= 1'b0;
            mac_store       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        busy      <= 1'b1;
                        mac_store <= 1'b1;
                        n_idx     <= '0;
                        w_base    <= '0;
                    end
                end
                S_CLEAR: begin
                    state     <= S_FETCH;
                    act_rd_en <= 1'b1;
                    act_addr  <= '0;
                    w_addr    <= w_base;
                end
                S_FETCH: begin
                    if (act_addr == K_LAST) begin
                        state     <= S_DRAIN;
                        act_rd_en <= 1'b0;
                    end else begin
                        act_addr <= act_addr + 1'b1;
                        w_addr   <= w_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state     <= S_STORE;
                    mac_store <= 1'b1;
                end
                S_STORE: begin
                    if (mac_result_valid) begin
                        out_data  <= mac_result;
                        out_idx   <= n_idx;
                        out_valid <= 1'b1;
                    end
                    if (n_idx == N_LAST) begin
                        state    <= S_FINISH;
                        done     <= 1'b1;
                        act_addr <= '0;
                        w_addr   <= '0;
                    end else begin
                        // Next neuron's weight row starts IN_LEN further on; no multiplier needed.
                        state     <= S_FETCH;
                        n_idx     <= n_idx + 1'b1;
                        w_base    <= w_base + W_STEP;
                        w_addr    <= w_base + W_STEP;
                        act_addr  <= '0;
                        act_rd_en <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
